// File: rtl/mul_pkg.sv
// Shared types and iteration-count helper for the radix-4 Booth multiplier.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    SEL_ZERO,
    SEL_PM,
    SEL_P2M,
    SEL_NM,
    SEL_N2M
  } booth_sel_t;

  // An unsigned-capable build needs one extra digit to consume the zero-extended top bits.
  function automatic int unsigned ITER_CALC(input int unsigned width, input bit signed_sel_en);
    return signed_sel_en ? (width / 2 + 1) : (width / 2);
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth digit recoder: maps a 3-bit multiplier window to the addend
// {0, +M, +2M, -M, -2M}; negatives are returned as ~value with cin=1.
module booth_r4_encoder
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       win,
  input  logic [WIDTH+1:0] m,
  output logic [WIDTH+1:0] addend,
  output logic             cin
);

  booth_sel_t sel;

  always_comb begin
    sel = SEL_ZERO;
    case (win)
      3'b001, 3'b010: sel = SEL_PM;
      3'b011:         sel = SEL_P2M;
      3'b100:         sel = SEL_N2M;
      3'b101, 3'b110: sel = SEL_NM;
      default:        sel = SEL_ZERO;
    endcase
  end

  always_comb begin
    addend = '0;
    cin    = 1'b0;
    case (sel)
      SEL_PM:  addend = m;
      SEL_P2M: addend = {m[WIDTH:0], 1'b0};
      SEL_NM: begin
        addend = ~m;
        cin    = 1'b1;
      end
      SEL_N2M: begin
        addend = ~{m[WIDTH:0], 1'b0};
        cin    = 1'b1;
      end
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, two multiplier bits per clock, result {HI, LO}.
// Optional MUL_UNSIGNED_SEL_EN adds an is_signed input selecting operand signedness.
module booth_r4_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
`ifdef MUL_UNSIGNED_SEL_EN
  input  logic               is_signed,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] out
);

`ifdef MUL_UNSIGNED_SEL_EN
  localparam bit SEL_EN = 1'b1;
`else
  localparam bit SEL_EN = 1'b0;
`endif
  localparam int ITER = int'(ITER_CALC(WIDTH, SEL_EN));
  localparam int QW   = 2 * ITER;
  localparam int PW   = (WIDTH + 2) + QW + 1;
  localparam int CW   = $clog2(ITER);

  state_t              state, state_nx;
  logic                accept, last;
  logic [WIDTH+1:0]    m_reg, m_ext;
  logic [QW-1:0]       q_ext;
  logic [PW-1:0]       p, p_next;
  logic [CW-1:0]       count;
  logic [WIDTH+1:0]    addend, sum;
  logic                cin;

`ifdef MUL_UNSIGNED_SEL_EN
  // Multiplier field is widened by two so the extra digit sees sign/zero fill, not product bits.
  always_comb begin
    m_ext = {{2{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
    q_ext = {{2{is_signed & multiplier[WIDTH-1]}}, multiplier};
  end
`else
  always_comb begin
    m_ext = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    q_ext = multiplier;
  end
`endif

  booth_r4_encoder #(.WIDTH(WIDTH)) u_enc (
    .win    (p[2:0]),
    .m      (m_reg),
    .addend (addend),
    .cin    (cin)
  );

  always_comb begin
    sum    = p[PW-1:QW+1] + addend + {{(WIDTH+1){1'b0}}, cin};
    p_next = {sum[WIDTH+1], sum[WIDTH+1], sum, p[QW:2]};
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (count == CW'(ITER - 1)) begin
          last     = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept   = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      m_reg <= '0;
      p     <= '0;
      count <= '0;
      out   <= '0;
    end else if (accept) begin
      m_reg <= m_ext;
      p     <= {{(WIDTH+2){1'b0}}, q_ext, 1'b0};
      count <= '0;
    end else if (state == RUN) begin
      p     <= p_next;
      count <= count + CW'(1);
      if (last) out <= p_next[2*WIDTH:1];
    end
  end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed self-checking bench for booth_r4_multiplier (WIDTH=32).
// Honours MUL_UNSIGNED_SEL_EN when the design is built with it.
module tb_booth_r4_multiplier;

  localparam int WIDTH = 32;
`ifdef MUL_UNSIGNED_SEL_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 17;
`endif

  logic              clock = 1'b0;
  logic              clear_n;
  logic              start;
  logic [WIDTH-1:0]  multiplicand;
  logic [WIDTH-1:0]  multiplier;
  logic              sgn;
  logic              busy;
  logic              done;
  logic [2*WIDTH-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  booth_r4_multiplier #(.WIDTH(WIDTH)) dut (
    .clock        (clock),
    .clear_n      (clear_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
`ifdef MUL_UNSIGNED_SEL_EN
    .is_signed    (sgn),
`endif
    .busy         (busy),
    .done         (done),
    .out          (out)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Latency counts edges from the accepting edge (1) to the edge after which done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat);
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat);
    res = out;
  endtask

  logic [63:0] res;
  logic [63:0] exp_v;
  logic [63:0] ea, eb;
  int          lat;
  int          seen;

  initial begin
    clear_n      = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    sgn          = 1'b1;

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_out",  out, 64'd0);
    clear_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(done), 64'd0);

    do_mul(32'd7, 32'hFFFF_FFFD, res, lat);
    check("7x-3", res, 64'hFFFF_FFFF_FFFF_FFEB);
    check("7x-3_lat", 64'(lat), 64'(LAT));
    @(posedge clock);
    #1;
    check("done_pulse", 64'(done), 64'd0);
    check("hold_out", out, 64'hFFFF_FFFF_FFFF_FFEB);

    // out keeps the old result while a new product is in flight
    multiplicand = 32'd0;
    multiplier   = 32'h1234_5678;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_run", 64'(busy), 64'd1);
    check("out_kept", out, 64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(lat);
    check("0xN", out, 64'd0);

    do_mul(32'h8000_0000, 32'h8000_0000, res, lat);
    check("min_sq", res, 64'h4000_0000_0000_0000);
    do_mul(32'h7FFF_FFFF, 32'h8000_0000, res, lat);
    check("max_x_min", res, 64'hC000_0000_8000_0000);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("m1xm1", res, 64'd1);
    do_mul(32'h0001_2345, 32'hFFFF_FFFF, res, lat);
    check("n_x_m1", res, 64'hFFFF_FFFF_FFFE_DCBB);

    // start pulsed during RUN must be ignored
    multiplicand = 32'd3;
    multiplier   = 32'd4;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    multiplicand = 32'd100;
    multiplier   = 32'd100;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    lat = 5;
    while (!done && lat < 64) begin
      @(posedge clock);
      #1;
      lat++;
    end
    check("ign_res", out, 64'd12);
    check("ign_lat", 64'(lat), 64'(LAT));

    // start held through DONE: back-to-back with no idle cycle
    multiplicand = 32'd2;
    multiplier   = 32'd9;
    start        = 1'b1;
    @(posedge clock);
    #1;
    wait_done(lat);
    check("b2b_first", out, 64'd18);
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("b2b_busy", 64'(busy), 64'd1);
    wait_done(lat);
    check("b2b_second", out, 64'd143);
    check("b2b_lat", 64'(lat), 64'(LAT));

    // abort mid-run
    multiplicand = 32'd1000;
    multiplier   = 32'd1000;
    start        = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    check("abort_pre_busy", 64'(busy), 64'd1);
    clear_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_out",  out, 64'd0);
    #3;
    clear_n = 1'b1;
    seen = 0;
    repeat (24) begin
      @(posedge clock);
      #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);
    do_mul(32'd5, 32'd6, res, lat);
    check("5x6", res, 64'd30);

`ifdef MUL_UNSIGNED_SEL_EN
    sgn = 1'b0;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("u_max_sq", res, 64'hFFFF_FFFE_0000_0001);
    check("u_lat", 64'(lat), 64'd18);
    sgn = 1'b1;
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat);
    check("s_m1xm1", res, 64'd1);
    check("s_lat", 64'(lat), 64'd18);
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] a, b;
      a   = $urandom;
      b   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      ea  = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      eb  = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      exp_v = ea * eb;
      do_mul(a, b, res, lat);
      check("rand", res, exp_v);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
